// File: rtl/axi4l_regfile_arbiter.sv
// Round-robin sequencer that shares one single-port register file between
// the AXI4-lite write-channel slave and read-channel slave.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no access in flight; readies offered to the arbitration winner
// WR       | register-file write strobe and write-done pulse
// RD_ISSUE | register-file read strobe
// RD_WAIT  | down-count RD_LATENCY cycles, capture read data at terminal count
module axi4l_regfile_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16,
  parameter int RD_LATENCY = 1
) (
  input  logic                    i_axi_clock,
  input  logic                    i_axi_areset,
  input  logic [ADDR_WIDTH-1:0]   i_wr_addr,
  input  logic [DATA_WIDTH-1:0]   i_wr_data,
  input  logic [DATA_WIDTH/8-1:0] i_wr_strb,
  input  logic                    i_wr_valid,
  output logic                    o_wr_ready,
  output logic                    o_wr_done,
  output logic                    o_wr_err,
  input  logic [ADDR_WIDTH-1:0]   i_rd_addr,
  input  logic                    i_rd_valid,
  output logic                    o_rd_ready,
  output logic [DATA_WIDTH-1:0]   o_rd_data,
  output logic                    o_rd_valid,
  output logic                    o_rd_err,
  output logic [ADDR_WIDTH-1:0]   o_rf_addr,
  output logic [DATA_WIDTH-1:0]   o_rf_wdata,
  output logic [DATA_WIDTH/8-1:0] o_rf_wstrb,
  output logic                    o_rf_we,
  output logic                    o_rf_re,
  input  logic [DATA_WIDTH-1:0]   i_rf_rdata,
  output logic                    o_busy
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int ASHIFT = $clog2(STRB_W);
  localparam logic [ADDR_WIDTH-1:0] NREGS = ADDR_WIDTH'(NUM_REGS);
  localparam logic [1:0] WAIT_LOAD = 2'(RD_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WR, RD_ISSUE, RD_WAIT} state_t;

  state_t                state;
  logic                  last_rd;
  logic                  rd_oor;
  logic [1:0]            wait_cnt;
  logic                  grant_wr;
  logic                  grant_rd;
  logic [ADDR_WIDTH-1:0] wr_idx;
  logic [ADDR_WIDTH-1:0] rd_idx;
  logic                  wr_in_range;
  logic                  rd_in_range;

  // Round-robin: on contention the requester not served last wins.
  assign grant_wr = i_wr_valid && (!i_rd_valid || last_rd);
  assign grant_rd = i_rd_valid && (!i_wr_valid || !last_rd);

  // Readies are gated by reset so every output is quiet while reset is held.
  assign o_wr_ready = (state == IDLE) && !i_axi_areset && grant_wr;
  assign o_rd_ready = (state == IDLE) && !i_axi_areset && grant_rd;

  assign wr_idx      = i_wr_addr >> ASHIFT;
  assign rd_idx      = i_rd_addr >> ASHIFT;
  assign wr_in_range = wr_idx < NREGS;
  assign rd_in_range = rd_idx < NREGS;

  assign o_busy = (state != IDLE);

  // Sequencer: captures the granted request and drives all pulses as registers.
  always_ff @(posedge i_axi_clock or posedge i_axi_areset) begin
    if (i_axi_areset) begin
      state      <= IDLE;
      last_rd    <= 1'b1;
      rd_oor     <= 1'b0;
      wait_cnt   <= 2'd0;
      o_wr_done  <= 1'b0;
      o_wr_err   <= 1'b0;
      o_rd_data  <= '0;
      o_rd_valid <= 1'b0;
      o_rd_err   <= 1'b0;
      o_rf_addr  <= '0;
      o_rf_wdata <= '0;
      o_rf_wstrb <= '0;
      o_rf_we    <= 1'b0;
      o_rf_re    <= 1'b0;
    end else begin
      o_rf_we    <= 1'b0;
      o_rf_re    <= 1'b0;
      o_wr_done  <= 1'b0;
      o_wr_err   <= 1'b0;
      o_rd_valid <= 1'b0;
      o_rd_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (o_wr_ready) begin
            o_rf_addr  <= i_wr_addr;
            o_rf_wdata <= i_wr_data;
            o_rf_wstrb <= i_wr_strb;
            o_rf_we    <= wr_in_range;
            o_wr_done  <= 1'b1;
            o_wr_err   <= !wr_in_range;
            last_rd    <= 1'b0;
            state      <= WR;
          end else if (o_rd_ready) begin
            o_rf_addr <= i_rd_addr;
            o_rf_re   <= rd_in_range;
            rd_oor    <= !rd_in_range;
            last_rd   <= 1'b1;
            state     <= RD_ISSUE;
          end
        end
        WR: begin
          state <= IDLE;
        end
        RD_ISSUE: begin
          wait_cnt <= WAIT_LOAD;
          state    <= RD_WAIT;
        end
        RD_WAIT: begin
          if (wait_cnt == 2'd0) begin
            // Out-of-range reads never strobed the file, so return zero.
            o_rd_data  <= rd_oor ? '0 : i_rf_rdata;
            o_rd_valid <= 1'b1;
            o_rd_err   <= rd_oor;
            state      <= IDLE;
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4l_regfile_arbiter.sv
// Bench for axi4l_regfile_arbiter: a latency-1 instance with a register-file
// model checked through a scoreboard, plus a latency-3 instance for timing.
module tb_axi4l_regfile_arbiter;

  logic        clk = 1'b0;
  logic        rst;

  logic [31:0] wr_addr, wr_data, rd_addr;
  logic [3:0]  wr_strb;
  logic        wr_valid, rd_valid;
  logic        wr_ready, wr_done, wr_err, rd_ready, rd_dv, rd_err;
  logic [31:0] rd_dout, rf_addr, rf_wdata, rf_rdata;
  logic [3:0]  rf_wstrb;
  logic        rf_we, rf_re, busy;

  logic [31:0] r3_addr;
  logic        r3_valid;
  logic [31:0] w3_addr, w3_data;
  logic [3:0]  w3_strb;
  logic        w3_valid;
  logic        wr_ready3, wr_done3, wr_err3, rd_ready3, rd_dv3, rd_err3;
  logic [31:0] rd_dout3, rf_addr3, rf_wdata3, rf_rdata3;
  logic [3:0]  rf_wstrb3;
  logic        rf_we3, rf_re3, busy3;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {logic [31:0] data; logic err;} rd_exp_t;
  logic    exp_wr[$];
  rd_exp_t exp_rd[$];
  bit      grant_q[$];
  int      we_cnt = 0;
  int      re_cnt = 0;
  logic    mon_e;
  rd_exp_t mon_r;

  logic [31:0] mem [16];
  logic [31:0] s0, s1, s2;

  always #5 clk = ~clk;

  axi4l_regfile_arbiter #(.RD_LATENCY(1)) dut (
    .i_axi_clock(clk), .i_axi_areset(rst),
    .i_wr_addr(wr_addr), .i_wr_data(wr_data), .i_wr_strb(wr_strb),
    .i_wr_valid(wr_valid), .o_wr_ready(wr_ready), .o_wr_done(wr_done),
    .o_wr_err(wr_err), .i_rd_addr(rd_addr), .i_rd_valid(rd_valid),
    .o_rd_ready(rd_ready), .o_rd_data(rd_dout), .o_rd_valid(rd_dv),
    .o_rd_err(rd_err), .o_rf_addr(rf_addr), .o_rf_wdata(rf_wdata),
    .o_rf_wstrb(rf_wstrb), .o_rf_we(rf_we), .o_rf_re(rf_re),
    .i_rf_rdata(rf_rdata), .o_busy(busy)
  );

  axi4l_regfile_arbiter #(.RD_LATENCY(3)) dut3 (
    .i_axi_clock(clk), .i_axi_areset(rst),
    .i_wr_addr(w3_addr), .i_wr_data(w3_data), .i_wr_strb(w3_strb),
    .i_wr_valid(w3_valid), .o_wr_ready(wr_ready3), .o_wr_done(wr_done3),
    .o_wr_err(wr_err3), .i_rd_addr(r3_addr), .i_rd_valid(r3_valid),
    .o_rd_ready(rd_ready3), .o_rd_data(rd_dout3), .o_rd_valid(rd_dv3),
    .o_rd_err(rd_err3), .o_rf_addr(rf_addr3), .o_rf_wdata(rf_wdata3),
    .o_rf_wstrb(rf_wstrb3), .o_rf_we(rf_we3), .o_rf_re(rf_re3),
    .i_rf_rdata(rf_rdata3), .o_busy(busy3)
  );

  // Latency-1 register file; read data is zero except in the one valid cycle.
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (rf_we && rf_wstrb[b]) mem[rf_addr[5:2]][8*b +: 8] <= rf_wdata[8*b +: 8];
    rf_rdata <= rf_re ? mem[rf_addr[5:2]] : 32'h0;
  end

  // Latency-3 register file returning a fixed word only in the valid cycle.
  always @(posedge clk) begin
    s0 <= rf_re3 ? 32'h1234_5678 : 32'h0;
    s1 <= s0;
    s2 <= s1;
  end
  assign rf_rdata3 = s2;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: invariants, grant log and scoreboard pops on every completion.
  always @(negedge clk) begin
    if (!rst) begin
      chk("invariants", {60'd0, wr_ready && rd_ready, rf_we && rf_re,
                         wr_err && !wr_done, rd_err && !rd_dv}, 64'd0);
      if (wr_valid && wr_ready) grant_q.push_back(1'b0);
      if (rd_valid && rd_ready) grant_q.push_back(1'b1);
      if (rf_we) we_cnt++;
      if (rf_re) re_cnt++;
      if (wr_done) begin
        if (exp_wr.size() == 0) chk("wr_done_unexpected", 64'(wr_done), 64'd0);
        else begin
          mon_e = exp_wr.pop_front();
          chk("wr_err", 64'(wr_err), 64'(mon_e));
        end
      end
      if (rd_dv) begin
        if (exp_rd.size() == 0) chk("rd_valid_unexpected", 64'(rd_dv), 64'd0);
        else begin
          mon_r = exp_rd.pop_front();
          chk("rd_data", 64'(rd_dout), 64'(mon_r.data));
          chk("rd_err", 64'(rd_err), 64'(mon_r.err));
        end
      end
    end
  end

  task automatic check_reset_outs(input string tag);
    chk({tag, "_a"}, {rd_dout, rf_addr}, 64'd0);
    chk({tag, "_b"}, 64'({rf_wdata, rf_wstrb, wr_ready, wr_done, wr_err, rd_ready,
                          rd_dv, rd_err, rf_we, rf_re, busy}), 64'd0);
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after the transfer.
  task automatic wr_issue(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output int waited);
    wr_addr = a; wr_data = d; wr_strb = s; wr_valid = 1'b1; waited = 0;
    while (1) begin
      @(negedge clk);
      if (wr_ready) break;
      waited++;
      if (waited >= 20) begin chk("wr_grant", 64'(wr_ready), 64'd1); break; end
    end
    @(posedge clk); #1 wr_valid = 1'b0;
  endtask

  task automatic rd_issue(input logic [31:0] a, output int waited);
    rd_addr = a; rd_valid = 1'b1; waited = 0;
    while (1) begin
      @(negedge clk);
      if (rd_ready) break;
      waited++;
      if (waited >= 20) begin chk("rd_grant", 64'(rd_ready), 64'd1); break; end
    end
    @(posedge clk); #1 rd_valid = 1'b0;
  endtask

  task automatic run_both(input logic [31:0] wa, input logic [31:0] wd,
                          input logic [31:0] ra, input int n);
    int cnt = 0;
    int cyc = 0;
    wr_addr = wa; wr_data = wd; wr_strb = 4'hF; rd_addr = ra;
    wr_valid = 1'b1; rd_valid = 1'b1;
    while (cnt < n && cyc < 60) begin
      @(negedge clk);
      if (wr_ready || rd_ready) cnt++;
      cyc++;
    end
    chk("both_grant_count", 64'(cnt), 64'(n));
    @(posedge clk); #1 wr_valid = 1'b0; rd_valid = 1'b0;
  endtask

  initial begin
    int w;
    int g0;
    int we0, re0;
    int cyc;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    rst = 1'b1;
    wr_addr = 0; wr_data = 0; wr_strb = 0; wr_valid = 0; rd_addr = 0; rd_valid = 0;
    r3_addr = 0; r3_valid = 0; w3_addr = 0; w3_data = 0; w3_strb = 0; w3_valid = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outs("reset_outs");
    @(posedge clk); #1 rst = 1'b0;

    // Single write: ready in cycle 1, strobe and done in cycle 2.
    exp_wr.push_back(1'b0);
    wr_issue(32'h08, 32'hDEAD_BEEF, 4'hF, w);
    chk("wr_ready_cycle1", 64'(w), 64'd0);
    @(negedge clk);
    chk("wr_strobes", 64'({rf_we, rf_re, busy, wr_done}), 64'b1011);
    chk("wr_rf_addr", 64'(rf_addr), 64'h08);
    chk("wr_rf_wdata", 64'(rf_wdata), 64'hDEAD_BEEF);
    @(posedge clk); #1;

    // Read back: re one cycle after grant, valid two cycles after re.
    exp_rd.push_back('{32'hDEAD_BEEF, 1'b0});
    rd_issue(32'h08, w);
    @(negedge clk);
    chk("rd_re_after_grant", 64'({rf_re, rf_we}), 64'b10);
    @(negedge clk);
    chk("rd_valid_early", 64'(rd_dv), 64'd0);
    @(negedge clk);
    chk("rd_valid_2_after_re", 64'(rd_dv), 64'd1);
    @(posedge clk); #1;

    // Partial strobe write then readback: bytes 0 and 2 only.
    exp_wr.push_back(1'b0);
    wr_issue(32'h0C, 32'h1122_3344, 4'b0101, w);
    exp_rd.push_back('{32'h0022_0044, 1'b0});
    rd_issue(32'h0C, w);
    repeat (3) @(posedge clk); #1;

    // Continuous contention: last grant was a read, so W,R,W,R.
    g0 = grant_q.size();
    exp_wr.push_back(1'b0); exp_wr.push_back(1'b0);
    exp_rd.push_back('{32'hDEAD_BEEF, 1'b0}); exp_rd.push_back('{32'hDEAD_BEEF, 1'b0});
    run_both(32'h10, 32'hCAFE_F00D, 32'h08, 4);
    chk("grant_q_size", 64'(grant_q.size() - g0), 64'd4);
    if (grant_q.size() - g0 == 4)
      chk("grant_order", 64'({grant_q[g0], grant_q[g0+1], grant_q[g0+2], grant_q[g0+3]}),
          64'b0101);
    repeat (4) @(posedge clk); #1;

    // Out-of-range accesses: no strobes, error-qualified completions.
    we0 = we_cnt; re0 = re_cnt;
    exp_wr.push_back(1'b1);
    wr_issue(32'h40, 32'h0BAD_F00D, 4'hF, w);
    exp_rd.push_back('{32'h0, 1'b1});
    rd_issue(32'h44, w);
    repeat (3) @(posedge clk); #1;
    chk("oor_no_we", 64'(we_cnt - we0), 64'd0);
    chk("oor_no_re", 64'(re_cnt - re0), 64'd0);

    // Reset during RD_WAIT: outputs clear at once, no completion follows.
    rd_issue(32'h08, w);
    @(posedge clk); #1;
    chk("in_rd_wait", 64'(busy), 64'd1);
    rst = 1'b1;
    #1 check_reset_outs("midop_reset_outs");
    repeat (2) @(posedge clk); #1 rst = 1'b0;
    g0 = grant_q.size();
    exp_wr.push_back(1'b0);
    exp_rd.push_back('{32'hDEAD_BEEF, 1'b0});
    run_both(32'h14, 32'h55AA_55AA, 32'h08, 2);
    if (grant_q.size() > g0)
      chk("first_grant_after_reset", 64'(grant_q[g0]), 64'd0);
    else
      chk("grant_after_reset_seen", 64'(grant_q.size() - g0), 64'd1);
    repeat (4) @(posedge clk); #1;

    // Latency 3: valid exactly 4 cycles after re; busy until the valid cycle.
    r3_addr = 32'h0; r3_valid = 1'b1; cyc = 0;
    while (1) begin
      @(negedge clk);
      if (rd_ready3) break;
      cyc++;
      if (cyc >= 20) begin chk("rd3_grant", 64'(rd_ready3), 64'd1); break; end
    end
    @(posedge clk); #1 r3_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk($sformatf("lat3_cycle%0d", k), 64'({rf_re3, rd_dv3, busy3, rd_err3}),
          64'({k == 1, k == 5, (k >= 1 && k <= 4), 1'b0}));
    end
    chk("lat3_rd_data", 64'(rd_dout3), 64'h1234_5678);

    repeat (3) @(posedge clk);
    chk("exp_wr_drained", 64'(exp_wr.size()), 64'd0);
    chk("exp_rd_drained", 64'(exp_rd.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
